// File: rtl/sequenciador_instrucoes_if.sv
// RAM and ULA ports of the instruction sequencer.
// The master side drives the strobes/addresses; the slave side returns read data and the ULA result.
interface sequenciador_instrucoes_if;
  logic [3:0] mem_addr;
  logic       mem_rd;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       ula_en;
  logic [3:0] ula_opcode;
  logic [3:0] ula_operando;
  logic [7:0] ula_result;

  modport master (
    output mem_addr, mem_rd, mem_we, mem_wdata, ula_en, ula_opcode, ula_operando,
    input  mem_rdata, ula_result
  );

  modport slave (
    input  mem_addr, mem_rd, mem_we, mem_wdata, ula_en, ula_opcode, ula_operando,
    output mem_rdata, ula_result
  );
endinterface

// File: rtl/sequenciador_instrucoes.sv
// Fetch/decode/execute sequencer owning A, B, PC and IR; 3 cycles per instruction, +1 for loads, +ULA_LAT for ALU ops.
// No backpressure: RAM answers the cycle after mem_rd and the ULA after exactly ULA_LAT cycles (1..4).
module sequenciador_instrucoes #(
  parameter logic [3:0] RESET_PC = 4'h0,
  parameter int         ULA_LAT  = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  sequenciador_instrucoes_if.master        bus_if,
  output logic [7:0]                       reg_a_o,
  output logic [7:0]                       reg_b_o,
  output logic [3:0]                       pc_o,
  output logic [7:0]                       ir_o,
  output logic                             busy_o,
  output logic                             halted_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEMWB  = 3'd4;
  localparam logic [2:0] S_ALUWB  = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [2:0] LAT = 3'(ULA_LAT);

  logic [2:0] state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [2:0] cnt_q, cnt_d;

  logic [3:0] opcode;
  logic [3:0] operando;

  assign opcode   = ir_q[7:4];
  assign operando = ir_q[3:0];

  // Strobes are decoded from state so an asynchronous reset drops them in the same cycle.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    ir_d             = ir_q;
    a_d              = a_q;
    b_d              = b_q;
    cnt_d            = cnt_q;
    bus_if.mem_addr  = 4'h0;
    bus_if.mem_rd    = 1'b0;
    bus_if.mem_we    = 1'b0;
    bus_if.mem_wdata = 8'h00;
    bus_if.ula_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        bus_if.mem_addr = pc_q;
        bus_if.mem_rd   = 1'b1;
        state_d         = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = bus_if.mem_rdata;
        pc_d    = pc_q + 4'h1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          4'h1, 4'h2: begin
            bus_if.mem_addr = operando;
            bus_if.mem_rd   = 1'b1;
            state_d         = S_MEMWB;
          end
          4'h3: begin
            bus_if.mem_addr  = operando;
            bus_if.mem_wdata = a_q;
            bus_if.mem_we    = 1'b1;
          end
          4'h4, 4'h5, 4'h6, 4'h7: begin
            bus_if.ula_en = 1'b1;
            cnt_d         = 3'd1;
            state_d       = S_ALUWB;
          end
          4'h8: pc_d = operando;
          4'h9: if (a_q == 8'h00) pc_d = operando;
          4'hF: state_d = S_HALT;
          default: ;
        endcase
      end
      S_MEMWB: begin
        if (opcode == 4'h1) a_d = bus_if.mem_rdata;
        else                b_d = bus_if.mem_rdata;
        state_d = S_FETCH;
      end
      S_ALUWB: begin
        // cnt_q is the number of cycles since the ula_en pulse.
        if (cnt_q == LAT) begin
          a_d     = bus_if.ula_result;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_HALT: begin
        if (start_i) begin
          pc_d    = RESET_PC;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_if.ula_opcode   = opcode;
  assign bus_if.ula_operando = operando;

  assign reg_a_o  = a_q;
  assign reg_b_o  = b_q;
  assign pc_o     = pc_q;
  assign ir_o     = ir_q;
  assign busy_o   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted_o = (state_q == S_HALT);

endmodule

// File: tb/tb_sequenciador_instrucoes.sv
// Bench for sequenciador_instrucoes: two instances (ULA_LAT 1 and 3) with behavioural RAM and ULA models.
module tb_sequenciador_instrucoes;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             start_w [2];
  logic             load_w  [2];
  logic [15:0][7:0] img_w   [2];

  logic [7:0] a_w [2];
  logic [7:0] b_w [2];
  logic [3:0] pc_w [2];
  logic [7:0] ir_w [2];
  logic       busy_w [2];
  logic       halted_w [2];

  sequenciador_instrucoes_if bus0 ();
  sequenciador_instrucoes_if bus1 ();

  sequenciador_instrucoes #(.RESET_PC(4'h0), .ULA_LAT(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_w[0]), .bus_if(bus0),
    .reg_a_o(a_w[0]), .reg_b_o(b_w[0]), .pc_o(pc_w[0]), .ir_o(ir_w[0]),
    .busy_o(busy_w[0]), .halted_o(halted_w[0])
  );

  sequenciador_instrucoes #(.RESET_PC(4'h0), .ULA_LAT(3)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_w[1]), .bus_if(bus1),
    .reg_a_o(a_w[1]), .reg_b_o(b_w[1]), .pc_o(pc_w[1]), .ir_o(ir_w[1]),
    .busy_o(busy_w[1]), .halted_o(halted_w[1])
  );

  logic [3:0] m_addr [2];
  logic       m_rd [2];
  logic       m_we [2];
  logic [7:0] m_wdata [2];
  logic       u_en [2];
  logic [3:0] u_op [2];
  logic [7:0] rdata_q [2];
  logic [7:0] ures [2];
  logic [7:0] uval [2];
  logic [2:0] ucnt [2];
  logic [7:0] ram [2][16];

  assign m_addr[0] = bus0.mem_addr;   assign m_addr[1] = bus1.mem_addr;
  assign m_rd[0]   = bus0.mem_rd;     assign m_rd[1]   = bus1.mem_rd;
  assign m_we[0]   = bus0.mem_we;     assign m_we[1]   = bus1.mem_we;
  assign m_wdata[0]= bus0.mem_wdata;  assign m_wdata[1]= bus1.mem_wdata;
  assign u_en[0]   = bus0.ula_en;     assign u_en[1]   = bus1.ula_en;
  assign u_op[0]   = bus0.ula_opcode; assign u_op[1]   = bus1.ula_opcode;
  assign bus0.mem_rdata  = rdata_q[0];
  assign bus1.mem_rdata  = rdata_q[1];
  assign bus0.ula_result = ures[0];
  assign bus1.ula_result = ures[1];
  // Result is only valid exactly LAT cycles after the enable pulse; 8'hEE elsewhere.
  assign ures[0] = (ucnt[0] == 3'd1) ? uval[0] : 8'hEE;
  assign ures[1] = (ucnt[1] == 3'd3) ? uval[1] : 8'hEE;

  function automatic logic [7:0] ula_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h4:    return a + b;
      4'h5:    return a - b;
      4'h6:    return a & b;
      4'h7:    return a ^ b;
      default: return 8'hEE;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (load_w[k]) begin
        for (int i = 0; i < 16; i++) ram[k][i] <= img_w[k][i];
        ucnt[k] <= 3'd0;
      end else begin
        if (m_we[k]) ram[k][m_addr[k]] <= m_wdata[k];
        if (m_rd[k]) rdata_q[k] <= ram[k][m_addr[k]];
        if (u_en[k]) begin
          ucnt[k] <= 3'd1;
          uval[k] <= ula_f(u_op[k], a_w[k], b_w[k]);
        end else if (ucnt[k] != 3'd0 && ucnt[k] != 3'd7) begin
          ucnt[k] <= ucnt[k] + 3'd1;
        end
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk) start_w[k] = 1'b1;
    @(posedge clk);
    #1 start_w[k] = 1'b0;
  endtask

  task automatic load_and_start(input int k, input logic [15:0][7:0] img);
    rst_n     = 1'b0;
    img_w[k]  = img;
    load_w[k] = 1'b1;
    @(posedge clk);
    #1 load_w[k] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    pulse_start(k);
  endtask

  task automatic run_to_halt(input int k, output int cyc);
    int  c = 0;
    logic [2:0] prev = 3'b000;
    logic [2:0] cur;
    while (c < 300 && !halted_w[k]) begin
      cur = {m_rd[k], m_we[k], u_en[k]};
      chk("strobe exclusive", 32'($onehot0(cur)), 32'd1);
      chk("strobe single cycle", 32'(cur & prev), 32'd0);
      prev = cur;
      step();
      c++;
    end
    if (c >= 300) chk("halt timeout", 32'd0, 32'd1);
    cyc = c;
  endtask

  typedef struct {
    logic [15:0][7:0] img;
    logic [7:0]       exp_a;
    logic [7:0]       exp_b;
    logic [3:0]       exp_pc;
    int               exp_cyc;
    logic [7:0]       exp_m13;
  } vec_t;

  vec_t tv [7];

  initial begin
    int cyc;
    int en_cnt;
    logic [15:0][7:0] img;

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_w[k] = 1'b0;
      load_w[k]  = 1'b0;
      img_w[k]   = '0;
    end

    for (int i = 0; i < 7; i++) tv[i].img = '0;
    // Load, add, store, halt.
    tv[0].img[0] = 8'h1E; tv[0].img[1] = 8'h2F; tv[0].img[2] = 8'h40; tv[0].img[3] = 8'h3D;
    tv[0].img[4] = 8'hF0; tv[0].img[14] = 8'h05; tv[0].img[15] = 8'h03;
    tv[0].exp_a = 8'h08; tv[0].exp_b = 8'h03; tv[0].exp_pc = 4'h5; tv[0].exp_cyc = 18; tv[0].exp_m13 = 8'h08;
    // JZ taken with A=0.
    tv[1].img[0] = 8'h95; tv[1].img[5] = 8'hF0;
    tv[1].exp_a = 8'h00; tv[1].exp_b = 8'h00; tv[1].exp_pc = 4'h6; tv[1].exp_cyc = 6; tv[1].exp_m13 = 8'h00;
    // JZ not taken with A=1.
    tv[2].img[0] = 8'h1E; tv[2].img[1] = 8'h95; tv[2].img[2] = 8'hF0; tv[2].img[14] = 8'h01;
    tv[2].exp_a = 8'h01; tv[2].exp_b = 8'h00; tv[2].exp_pc = 4'h3; tv[2].exp_cyc = 10; tv[2].exp_m13 = 8'h00;
    // JMP over a HLT, SUB, opcode A as NOP, STA.
    tv[3].img[0] = 8'h1E; tv[3].img[1] = 8'h2F; tv[3].img[2] = 8'h87; tv[3].img[3] = 8'hF0;
    tv[3].img[7] = 8'h50; tv[3].img[8] = 8'hA0; tv[3].img[9] = 8'h3D; tv[3].img[10] = 8'hF0;
    tv[3].img[14] = 8'h09; tv[3].img[15] = 8'h04;
    tv[3].exp_a = 8'h05; tv[3].exp_b = 8'h04; tv[3].exp_pc = 4'hB; tv[3].exp_cyc = 24; tv[3].exp_m13 = 8'h05;
    // PC wrap: NOP at 15 wraps to 0, which STA has rewritten to HLT.
    tv[4].img[0] = 8'h1E; tv[4].img[1] = 8'h30; tv[4].img[2] = 8'h8F; tv[4].img[14] = 8'hF0;
    tv[4].exp_a = 8'hF0; tv[4].exp_b = 8'h00; tv[4].exp_pc = 4'h1; tv[4].exp_cyc = 16; tv[4].exp_m13 = 8'h00;
    // AND then XOR.
    tv[5].img[0] = 8'h1E; tv[5].img[1] = 8'h2F; tv[5].img[2] = 8'h60; tv[5].img[3] = 8'h70;
    tv[5].img[4] = 8'hF0; tv[5].img[14] = 8'h0C; tv[5].img[15] = 8'h0A;
    tv[5].exp_a = 8'h02; tv[5].exp_b = 8'h0A; tv[5].exp_pc = 4'h5; tv[5].exp_cyc = 19; tv[5].exp_m13 = 8'h00;
    // STA onto the very next instruction.
    tv[6].img[0] = 8'h1E; tv[6].img[1] = 8'h32; tv[6].img[2] = 8'h00; tv[6].img[3] = 8'h2F;
    tv[6].img[4] = 8'hF0; tv[6].img[14] = 8'hF0; tv[6].img[15] = 8'h77;
    tv[6].exp_a = 8'hF0; tv[6].exp_b = 8'h00; tv[6].exp_pc = 4'h3; tv[6].exp_cyc = 10; tv[6].exp_m13 = 8'h00;

    // Reset state, and no departure from IDLE without start.
    #12;
    chk("rst pc", 32'(pc_w[0]), 32'h0);
    chk("rst ir", 32'(ir_w[0]), 32'h0);
    chk("rst a", 32'(a_w[0]), 32'h0);
    chk("rst b", 32'(b_w[0]), 32'h0);
    chk("rst busy", 32'(busy_w[0]), 32'h0);
    chk("rst halted", 32'(halted_w[0]), 32'h0);
    chk("rst strobes", 32'({m_rd[0], m_we[0], u_en[0]}), 32'h0);
    chk("rst addr", 32'(m_addr[0]), 32'h0);
    chk("rst wdata", 32'(m_wdata[0]), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) step();
    chk("idle no start busy", 32'(busy_w[0]), 32'h0);
    chk("idle no start pc", 32'(pc_w[0]), 32'h0);

    for (int i = 0; i < 7; i++) begin
      load_and_start(0, tv[i].img);
      run_to_halt(0, cyc);
      chk($sformatf("v%0d cycles", i), 32'(cyc), 32'(tv[i].exp_cyc));
      chk($sformatf("v%0d reg_a", i), 32'(a_w[0]), 32'(tv[i].exp_a));
      chk($sformatf("v%0d reg_b", i), 32'(b_w[0]), 32'(tv[i].exp_b));
      chk($sformatf("v%0d pc", i), 32'(pc_w[0]), 32'(tv[i].exp_pc));
      chk($sformatf("v%0d ram13", i), 32'(ram[0][13]), 32'(tv[i].exp_m13));
      chk($sformatf("v%0d busy", i), 32'(busy_w[0]), 32'h0);
    end

    // Restart from HALT keeps A and reloads PC.
    load_and_start(0, tv[0].img);
    run_to_halt(0, cyc);
    chk("halt halted", 32'(halted_w[0]), 32'h1);
    pulse_start(0);
    chk("restart busy", 32'(busy_w[0]), 32'h1);
    chk("restart halted", 32'(halted_w[0]), 32'h0);
    chk("restart pc", 32'(pc_w[0]), 32'h0);
    chk("restart reg_a", 32'(a_w[0]), 32'h08);
    chk("restart fetch", 32'({m_rd[0], m_addr[0]}), 32'h10);

    // JZ taken cycle by cycle, with a start pulse during FETCH.
    img = '0;
    img[0] = 8'h95; img[5] = 8'hF0;
    load_and_start(0, img);
    chk("jz fetch", 32'({m_rd[0], m_addr[0]}), 32'h10);
    pulse_start(0);
    chk("jz decode pc", 32'(pc_w[0]), 32'h0);
    chk("jz decode busy", 32'(busy_w[0]), 32'h1);
    step();
    chk("jz exec pc", 32'(pc_w[0]), 32'h1);
    chk("jz exec ir", 32'(ir_w[0]), 32'h95);
    step();
    chk("jz taken pc", 32'(pc_w[0]), 32'h5);
    chk("jz next fetch", 32'({m_rd[0], m_addr[0]}), 32'h15);

    // ULA_LAT=3: add occupies cycles 8..13, A written at the end of cycle 13.
    img = '0;
    img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h40; img[3] = 8'hF0; img[14] = 8'h05; img[15] = 8'h03;
    load_and_start(1, img);
    en_cnt = 0;
    for (int c = 0; c < 17; c++) begin
      if (u_en[1]) en_cnt++;
      if (c == 10) chk("lat3 ula_en", 32'(u_en[1]), 32'h1);
      if (c == 13) chk("lat3 reg_a held", 32'(a_w[1]), 32'h05);
      if (c == 16) chk("lat3 not yet halted", 32'(halted_w[1]), 32'h0);
      step();
    end
    chk("lat3 ula_en count", 32'(en_cnt), 32'd1);
    chk("lat3 halted", 32'(halted_w[1]), 32'h1);
    chk("lat3 reg_a", 32'(a_w[1]), 32'h08);

    // Reset during the STA write cycle.
    img = '0;
    img[0] = 8'h1E; img[1] = 8'h3D; img[2] = 8'hF0; img[13] = 8'h55; img[14] = 8'hAB;
    load_and_start(0, img);
    repeat (6) step();
    chk("sta we", 32'({m_we[0], m_addr[0], m_wdata[0]}), 32'h1DAB);
    #2 rst_n = 1'b0;
    #1;
    chk("rst mid we", 32'(m_we[0]), 32'h0);
    chk("rst mid busy", 32'(busy_w[0]), 32'h0);
    chk("rst mid pc", 32'(pc_w[0]), 32'h0);
    chk("rst mid reg_a", 32'(a_w[0]), 32'h0);
    chk("rst mid addr/wdata", 32'({m_addr[0], m_wdata[0]}), 32'h0);
    step();
    chk("rst mid ram13", 32'(ram[0][13]), 32'h55);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) step();
    chk("rst mid stays idle", 32'(busy_w[0]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
